// File: rtl/spi_adc_responder_pkg.sv
// Shared types and constants for the MCP300x-style SPI ADC responder.
package spi_adc_pkg;

    // Frame phases, from waiting for chip select through the trailing zeros.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CFG,
        NULL,
        MSB,
        LSB,
        TRAIL
    } state_t;

    // SGL/DIFF followed by D2..D0.
    localparam int CFG_BITS   = 4;
    localparam int ADC_DATA_W = 10;

endpackage

// File: rtl/spi_adc_responder_edge_sync.sv
// Multi-flop synchroniser with registered rise/fall strobes for one async pin.
module edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign sync_out = w_sync;
    assign rise     = r_rise;
    assign fall     = r_fall;

    // Shift the raw pin through the metastability chain; the top bit is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(async_in);
        end
    end

    // Compare against the previous synced value and register one-clk edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_rise <= w_sync & ~r_prev;
            r_fall <= ~w_sync & r_prev;
        end
    end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating an MCP300x ADC: decodes the config, requests a
// sample from local logic and shifts it back null-bit first, MSB-first.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CH_W        = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_TAIL    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_clk,
    input  logic              cs,
    input  logic              din,
    output logic              dout,
    output logic              dout_oe,
    output logic              sample_req,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_sgl,
    input  logic [DATA_W-1:0] sample_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [3:0] LAST_CFG = 4'(CFG_BITS - 1);
    localparam logic [3:0] TOP_BIT  = 4'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_dout;
    logic                r_b0_sent;
    logic                r_sgl_cap;
    logic [CH_W-1:0]     r_ch_cap;
    logic [CH_W-1:0]     r_sample_ch;
    logic                r_sample_sgl;
    logic                r_sample_req;
    logic                r_frame_done;
    logic                r_frame_err;

    logic                w_clk_sync;
    logic                w_clk_rise;
    logic                w_clk_fall;
    logic                w_cs_hi;
    logic                w_cs_rise;
    logic                w_cs_fall;
    logic                w_din;
    logic                w_din_rise;
    logic                w_din_fall;
    logic                w_abort;
    logic [CH_W-1:0]     w_ch_next;
    logic                w_unused_strobes;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ad_clk),
        .sync_out (w_clk_sync),
        .rise     (w_clk_rise),
        .fall     (w_clk_fall)
    );

    // cs resets to the deselected level so reset release never looks like a new frame.
    edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (cs),
        .sync_out (w_cs_hi),
        .rise     (w_cs_rise),
        .fall     (w_cs_fall)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (din),
        .sync_out (w_din),
        .rise     (w_din_rise),
        .fall     (w_din_fall)
    );

    // Only the ad_clk strobes, cs level and din level drive the frame logic.
    assign w_unused_strobes = ^{w_clk_sync, w_cs_rise, w_cs_fall, w_din_rise, w_din_fall};

    assign w_ch_next = (r_ch_cap << 1) | CH_W'(w_din);
    assign w_abort   = w_cs_hi && (r_state == CFG || r_state == NULL || r_state == MSB);

    assign sample_req = r_sample_req;
    assign sample_ch  = r_sample_ch;
    assign sample_sgl = r_sample_sgl;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a deselected cs overrides any same-cycle ad_clk edge.
    always_comb begin
        w_next = r_state;
        if (w_cs_hi) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:       w_next = WAIT_START;
                WAIT_START: if (w_clk_rise && w_din) w_next = CFG;
                CFG:        if (w_clk_rise && r_cnt == LAST_CFG) w_next = NULL;
                NULL:       if (w_clk_fall) w_next = MSB;
                MSB:        if (w_clk_rise && r_b0_sent) w_next = LSB_TAIL ? LSB : TRAIL;
                LSB:        if (w_clk_fall && r_cnt == TOP_BIT) w_next = TRAIL;
                default:    w_next = r_state;
            endcase
        end
    end

    // Output decode; dout is gated so it reads 0 whenever the pin is not driven.
    always_comb begin
        dout_oe = 1'b0;
        busy    = 1'b0;
        case (r_state)
            CFG, NULL:       busy = 1'b1;
            MSB, LSB, TRAIL: begin
                dout_oe = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
        dout = r_dout & dout_oe;
    end

    // Config capture, sample latch, bit counter and the registered dout bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= 1'b0;
            r_b0_sent    <= 1'b0;
            r_sgl_cap    <= 1'b0;
            r_ch_cap     <= '0;
            r_sample_ch  <= '0;
            r_sample_sgl <= 1'b0;
            r_sample_req <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= w_abort;
            // Local logic presents its value while sample_req is high; freeze it for the frame.
            if (r_sample_req) begin
                r_shift <= sample_data;
            end
            if (w_cs_hi) begin
                r_dout    <= 1'b0;
                r_cnt     <= '0;
                r_b0_sent <= 1'b0;
            end else begin
                case (r_state)
                    CFG: begin
                        if (w_clk_rise) begin
                            if (r_cnt == 4'd0) begin
                                r_sgl_cap <= w_din;
                            end else begin
                                r_ch_cap <= w_ch_next;
                            end
                            if (r_cnt == LAST_CFG) begin
                                r_sample_req <= 1'b1;
                                r_sample_ch  <= w_ch_next;
                                r_sample_sgl <= r_sgl_cap;
                                r_cnt        <= '0;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                    end
                    NULL: begin
                        if (w_clk_fall) begin
                            r_dout <= 1'b0;
                            r_cnt  <= TOP_BIT;
                        end
                    end
                    MSB: begin
                        if (w_clk_fall) begin
                            r_dout <= r_shift[r_cnt];
                            if (r_cnt == 4'd0) begin
                                r_b0_sent <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                            end
                        end else if (w_clk_rise && r_b0_sent) begin
                            r_frame_done <= 1'b1;
                            r_b0_sent    <= 1'b0;
                            r_cnt        <= 4'd1;
                        end
                    end
                    LSB: begin
                        if (w_clk_fall) begin
                            r_dout <= r_shift[r_cnt];
                            r_cnt  <= r_cnt + 4'd1;
                        end
                    end
                    TRAIL: begin
                        if (w_clk_fall) begin
                            r_dout <= 1'b0;
                        end
                    end
                    default: begin
                        r_cnt     <= '0;
                        r_b0_sent <= 1'b0;
                        r_dout    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: an SPI mode-0 initiator model drives
// frames while a compare process checks dout against a frame-position model.
`timescale 1ns/100ps
module tb_spi_adc_responder;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ad_clk = 1'b0;
    logic       cs = 1'b1;
    logic       din = 1'b0;
    logic [9:0] sample_data = 10'h000;

    logic       a_dout, a_oe, a_req, a_sgl, a_done, a_err, a_busy;
    logic [2:0] a_ch;
    logic       b_dout, b_oe, b_req, b_sgl, b_done, b_err, b_busy;
    logic [2:0] b_ch;

    int total = 0;
    int bad   = 0;
    int n_req = 0, n_done = 0, n_err = 0;
    int s_req, s_done, s_err;

    int          m_pos = -1;
    logic [9:0]  m_val = 10'h000;
    logic [10:0] rd_word;
    logic [8:0]  tail_a, tail_b;
    bit          t6_seen;

    spi_adc_responder #(.DATA_W(10), .CH_W(3), .SYNC_STAGES(SYNC), .LSB_TAIL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
        .dout(a_dout), .dout_oe(a_oe), .sample_req(a_req), .sample_ch(a_ch),
        .sample_sgl(a_sgl), .sample_data(sample_data), .frame_done(a_done),
        .frame_err(a_err), .busy(a_busy)
    );

    spi_adc_responder #(.DATA_W(10), .CH_W(3), .SYNC_STAGES(SYNC), .LSB_TAIL(1'b0)) dut_notail (
        .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
        .dout(b_dout), .dout_oe(b_oe), .sample_req(b_req), .sample_ch(b_ch),
        .sample_sgl(b_sgl), .sample_data(sample_data), .frame_done(b_done),
        .frame_err(b_err), .busy(b_busy)
    );

    always #18.5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value the initiator must read at data position pos (0 = null bit).
    function automatic logic model_bit(input logic [9:0] v, input int pos, input bit tail);
        if (pos >= 1 && pos <= 10) return v[10 - pos];
        if (tail && pos >= 11 && pos <= 19) return v[pos - 10];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (a_req)  n_req++;
        if (a_done) n_done++;
        if (a_err)  n_err++;
    end

    // At every initiator sampling edge compare the pin against the model.
    always @(posedge ad_clk) begin
        @(negedge clk);
        if (m_pos < 0) begin
            chk("oe_before_data", a_oe, 1'b0);
            chk("oe_before_data_notail", b_oe, 1'b0);
        end else begin
            chk($sformatf("oe@%0d", m_pos), a_oe, 1'b1);
            chk($sformatf("busy@%0d", m_pos), a_busy, 1'b1);
            chk($sformatf("dout@%0d", m_pos), a_dout, model_bit(m_val, m_pos, 1'b1));
            chk($sformatf("dout_notail@%0d", m_pos), b_dout, model_bit(m_val, m_pos, 1'b0));
            if (m_pos <= 10) begin
                rd_word[10 - m_pos] = a_dout;
            end else if (m_pos <= 19) begin
                tail_a[m_pos - 11] = a_dout;
                tail_b[m_pos - 11] = b_dout;
            end
        end
    end

    task automatic send_bit(input logic b, input int pos);
        din   = b;
        m_pos = pos;
        #500 ad_clk = 1'b1;
        #500 ad_clk = 1'b0;
    endtask

    task automatic send_cfg(input int lead, input logic sgl, input logic [2:0] ch);
        for (int i = 0; i < lead; i++) send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(sgl, -1);
        for (int i = 2; i >= 0; i--) send_bit(ch[i], -1);
    endtask

    task automatic frame(input logic [9:0] val, input int lead, input logic sgl,
                         input logic [2:0] ch, input int ndata, input int abort_after);
        sample_data = val;
        m_val       = val;
        rd_word     = 'x;
        tail_a      = 'x;
        tail_b      = 'x;
        cs = 1'b0;
        #700;
        send_cfg(lead, sgl, ch);
        for (int n = 0; n < ndata; n++) begin
            send_bit(1'b0, n);
            if (n == abort_after) break;
        end
        din   = 1'b0;
        m_pos = -1;
        cs    = 1'b1;
    endtask

    task automatic snap();
        s_req  = n_req;
        s_done = n_done;
        s_err  = n_err;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", a_dout, 1'b0);
        chk("rst_oe", a_oe, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_req", a_req, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_ch", a_ch, 3'd0);
        chk("rst_sgl", a_sgl, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single-ended ch0, 8 leading zeros
        snap();
        frame(10'h2A5, 8, 1'b1, 3'd0, 11, -1);
        #2000;
        chk("t1_req_count", n_req - s_req, 1);
        chk("t1_done_count", n_done - s_done, 1);
        chk("t1_err_count", n_err - s_err, 0);
        chk("t1_ch", a_ch, 3'd0);
        chk("t1_sgl", a_sgl, 1'b1);
        chk("t1_word", rd_word, 11'b0_1010100101);
        chk("t1_idle_oe", a_oe, 1'b0);
        chk("t1_idle_busy", a_busy, 1'b0);

        // 2: differential ch5, all ones
        snap();
        frame(10'h3FF, 0, 1'b0, 3'd5, 11, -1);
        #2000;
        chk("t2_ch", a_ch, 3'd5);
        chk("t2_sgl", a_sgl, 1'b0);
        chk("t2_word", rd_word, 11'h3FF);
        chk("t2_done_count", n_done - s_done, 1);

        // 3: LSB tail then trailing zeros
        frame(10'h2A5, 1, 1'b1, 3'd1, 24, -1);
        #2000;
        chk("t3_word", rd_word, 11'h2A5);
        chk("t3_tail", tail_a, 9'h152);
        chk("t3_tail_notail", tail_b, 9'h000);

        // 4: abort after the fifth MSB bit
        snap();
        frame(10'h2A5, 2, 1'b1, 3'd3, 11, 5);
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        chk("t4_oe_off", a_oe, 1'b0);
        chk("t4_busy_off", a_busy, 1'b0);
        chk("t4_dout_off", a_dout, 1'b0);
        #2000;
        chk("t4_err_count", n_err - s_err, 1);
        chk("t4_done_count", n_done - s_done, 0);
        snap();
        frame(10'h1C3, 0, 1'b1, 3'd7, 11, -1);
        #2000;
        chk("t4_next_word", rd_word, 11'h1C3);
        chk("t4_next_ch", a_ch, 3'd7);
        chk("t4_next_done", n_done - s_done, 1);
        chk("t4_next_err", n_err - s_err, 0);

        // 5: reset during MSB phase
        sample_data = 10'h2A5;
        m_val       = 10'h2A5;
        cs = 1'b0;
        #700;
        send_cfg(0, 1'b1, 3'd2);
        send_bit(1'b0, 0);
        send_bit(1'b0, 1);
        send_bit(1'b0, 2);
        repeat (6) @(negedge clk);
        chk("t5_pre_oe", a_oe, 1'b1);
        chk("t5_pre_dout", a_dout, 1'b1);
        chk("t5_pre_ch", a_ch, 3'd2);
        #3 rst_n = 1'b0;
        #2;
        chk("t5_async_dout", a_dout, 1'b0);
        chk("t5_async_oe", a_oe, 1'b0);
        chk("t5_async_busy", a_busy, 1'b0);
        chk("t5_async_ch", a_ch, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) send_bit(1'b0, -1);
        rd_word = 'x;
        send_cfg(0, 1'b1, 3'd4);
        for (int n = 0; n < 11; n++) send_bit(1'b0, n);
        din   = 1'b0;
        m_pos = -1;
        cs    = 1'b1;
        #2000;
        chk("t5_fresh_word", rd_word, 11'h2A5);
        chk("t5_fresh_ch", a_ch, 3'd4);

        // 6: sample_data changes after it was latched
        t6_seen = 1'b0;
        fork
            frame(10'h2A5, 3, 1'b1, 3'd6, 11, -1);
            begin
                for (int i = 0; i < 3000 && !t6_seen; i++) begin
                    @(negedge clk);
                    if (a_req) t6_seen = 1'b1;
                end
                @(posedge clk);
                #1 sample_data = 10'h000;
            end
        join
        #2000;
        chk("t6_req_seen", t6_seen, 1'b1);
        chk("t6_word", rd_word, 11'h2A5);
        chk("t6_ch", a_ch, 3'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
